hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage MIPS datapath (IF/ID/EXE/MEM/WB).
- Keeps an internal scoreboard of destination registers in flight in EXE, MEM and WB.
- Compares the decoding instruction's sources against that scoreboard and drives freeze/flush/bubble controls to PC_reg and the pipeline registers.
- Also handles taken-branch flushes and memory-busy freezes, and counts stall cycles for performance debug.

Parameters:
- REG_AW, 5, register address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_src1  in  REG_AW  ID first source register
- id_src2  in  REG_AW  ID second source register
- id_two_src  in  1  instruction reads src2 (R-type, ST, branches 41/42)
- id_dest  in  REG_AW  ID destination register
- id_wb_en  in  1  ID instruction writes the register file (Control_unit WB_EN)
- id_mem_r  in  1  ID instruction is a load (Control_unit MEM_R)
- br_taken  in  1  branch in EXE resolved taken
- mem_busy  in  1  data memory not ready; whole pipe must hold
- pc_freeze  out  1  hold PC_reg
- ifid_freeze  out  1  hold IF/ID register
- ifid_flush  out  1  clear IF/ID register to NOP
- idex_bubble  out  1  load NOP into ID/EXE instead of the ID instruction
- pipe_freeze  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers
- stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset is synchronous, active-high, on posedge clk.
  - Scoreboard slots EXE/MEM/WB go invalid.
  - stall_cnt = 0.
  - All combinational outputs evaluate to 0 while slots are invalid and inputs are idle.
- Each scoreboard slot holds {valid, dest, wb_en, mem_r}.
- A slot "hits" a source s when all of these hold: valid, wb_en, dest == s, and s != 0. Register 0 never hazards.
- Source-hit rule: src1 is always checked; src2 is checked only when id_two_src = 1.
- hazard = id_valid AND (src1 hits EXE or MEM) OR (src2 hits EXE or MEM). WB is not checked without the optional feature, because the register file writes in the first half-cycle.
- Output priority, combinational, same cycle as inputs:
  1. mem_busy = 1: pc_freeze = ifid_freeze = pipe_freeze = 1. Flush and bubble are 0. br_taken is ignored; the branch stays in EXE and is re-presented.
  2. br_taken = 1: ifid_flush = 1 and idex_bubble = 1. PC is not frozen, so it loads the target. hazard is ignored.
  3. hazard = 1: pc_freeze = ifid_freeze = idex_bubble = 1.
  4. Otherwise all outputs are 0.
- Slot update at posedge when mem_busy = 0:
  - WB <= MEM and MEM <= EXE.
  - EXE <= invalid if idex_bubble = 1 or id_valid = 0; otherwise EXE <= the ID fields.
- Slot update when mem_busy = 1: all slots hold.
- stall_cnt increments by 1 on each clock where case 3 is the active output. It saturates at all-ones and never wraps.
- A hazard persists across cycles: each stall cycle ages the producer one stage until no hit remains. Without forwarding this gives at most 2 stall cycles.
- rst asserted mid-stall or mid-busy: the next cycle shows all outputs 0 and an empty scoreboard.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- When defined:
  - Adds output ports fwd_sel_a and fwd_sel_b, each 2 bits, registered.
  - Values are captured at the clock that loads EXE, so they are valid while the instruction sits in EXE.
  - Encoding: 00 = register file, 01 = EXE/MEM result, 10 = MEM/WB result. The younger producer wins: a hit in the EXE slot gives 01, else a hit in the MEM slot gives 10.
  - hazard then reduces to load-use only: a source hits the EXE slot and that slot has mem_r = 1. This gives exactly 1 stall cycle.
  - The fwd_sel registers reset to 00, hold during mem_busy, and load 00 when a bubble enters EXE.
- When undefined: the ports are absent and the full EXE/MEM stall rule applies.

Test Plan:
- Reset then idle (id_valid = 0, 4 cycles): all outputs 0, stall_cnt = 0.
- ADD writes r3, followed next cycle by SUB reading src1 = r3 (no forwarding): pc_freeze/ifid_freeze/idex_bubble high for exactly 2 cycles, then the SUB issues; stall_cnt = 2.
- Same pair with dest = r0: no stall.
- Same pair with src2 = r3 and id_two_src = 0: no stall.
- Hazard pending and br_taken = 1 in the same cycle: ifid_flush = 1, idex_bubble = 1, pc_freeze = 0; stall_cnt unchanged.
- mem_busy held 3 cycles during a 2-cycle hazard: pc_freeze/pipe_freeze high throughout, scoreboard frozen. After release the remaining hazard stalls resume, and stall_cnt counts only non-busy stall cycles (2).
- HAZARD_FORWARD_EN defined:
  - LD r5 then ADD reading r5: exactly 1 stall, then fwd_sel_a = 10 while the ADD is in EXE.
  - ADDI r6 then SUB reading src2 = r6: no stall, fwd_sel_b = 01.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: EXE/MEM destination scoreboard,
// branch flush, memory-busy freeze and a saturating stall counter. Optional macro: HAZARD_FORWARD_EN.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r,
  input  logic              br_taken,
  input  logic              mem_busy,
  output logic              pc_freeze,
  output logic              ifid_freeze,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
`ifdef HAZARD_FORWARD_EN
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
`endif
  output logic [CNT_W-1:0]  stall_cnt
);

  // The WB occupant is never compared (the register file writes in the first
  // half-cycle), so only the EXE and MEM slots are stored.
  logic              exe_vld_q, exe_vld_d, exe_wb_q, exe_wb_d;
  logic [REG_AW-1:0] exe_dest_q, exe_dest_d;
  logic              mem_vld_q, mem_vld_d, mem_wb_q, mem_wb_d;
  logic [REG_AW-1:0] mem_dest_q, mem_dest_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              h1_exe, h1_mem, h2_exe, h2_mem, hazard, stall_active;
`ifdef HAZARD_FORWARD_EN
  logic              exe_mr_q, exe_mr_d;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
`endif

  function automatic logic slot_hit(input logic vld, input logic wb,
                                    input logic [REG_AW-1:0] dest,
                                    input logic [REG_AW-1:0] src);
    return vld & wb & (dest == src) & (src != '0);
  endfunction

  always_comb begin
    h1_exe = slot_hit(exe_vld_q, exe_wb_q, exe_dest_q, id_src1);
    h1_mem = slot_hit(mem_vld_q, mem_wb_q, mem_dest_q, id_src1);
    h2_exe = id_two_src & slot_hit(exe_vld_q, exe_wb_q, exe_dest_q, id_src2);
    h2_mem = id_two_src & slot_hit(mem_vld_q, mem_wb_q, mem_dest_q, id_src2);
`ifdef HAZARD_FORWARD_EN
    hazard = id_valid & (h1_exe | h2_exe) & exe_mr_q;
`else
    hazard = id_valid & (h1_exe | h1_mem | h2_exe | h2_mem);
`endif
  end

  // Priority: memory busy, then taken branch, then data hazard.
  always_comb begin
    pc_freeze    = 1'b0;
    ifid_freeze  = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    pipe_freeze  = 1'b0;
    stall_active = 1'b0;
    if (mem_busy) begin
      pc_freeze   = 1'b1;
      ifid_freeze = 1'b1;
      pipe_freeze = 1'b1;
    end else if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_freeze    = 1'b1;
      ifid_freeze  = 1'b1;
      idex_bubble  = 1'b1;
      stall_active = 1'b1;
    end else begin
      stall_active = 1'b0;
    end
  end

  always_comb begin
    exe_vld_d  = exe_vld_q;
    exe_wb_d   = exe_wb_q;
    exe_dest_d = exe_dest_q;
    mem_vld_d  = mem_vld_q;
    mem_wb_d   = mem_wb_q;
    mem_dest_d = mem_dest_q;
    cnt_d      = cnt_q;
`ifdef HAZARD_FORWARD_EN
    exe_mr_d   = exe_mr_q;
    fwd_a_d    = fwd_a_q;
    fwd_b_d    = fwd_b_q;
`endif
    if (!mem_busy) begin
      mem_vld_d  = exe_vld_q;
      mem_wb_d   = exe_wb_q;
      mem_dest_d = exe_dest_q;
      if (idex_bubble || !id_valid) begin
        exe_vld_d  = 1'b0;
        exe_wb_d   = 1'b0;
        exe_dest_d = '0;
`ifdef HAZARD_FORWARD_EN
        exe_mr_d   = 1'b0;
        fwd_a_d    = 2'b00;
        fwd_b_d    = 2'b00;
`endif
      end else begin
        exe_vld_d  = 1'b1;
        exe_wb_d   = id_wb_en;
        exe_dest_d = id_dest;
`ifdef HAZARD_FORWARD_EN
        exe_mr_d   = id_mem_r;
        fwd_a_d    = h1_exe ? 2'b01 : (h1_mem ? 2'b10 : 2'b00);
        fwd_b_d    = h2_exe ? 2'b01 : (h2_mem ? 2'b10 : 2'b00);
`endif
      end
    end else begin
      mem_vld_d = mem_vld_q;
    end
    if (stall_active && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_vld_q  <= 1'b0;
      exe_wb_q   <= 1'b0;
      exe_dest_q <= '0;
      mem_vld_q  <= 1'b0;
      mem_wb_q   <= 1'b0;
      mem_dest_q <= '0;
      cnt_q      <= '0;
`ifdef HAZARD_FORWARD_EN
      exe_mr_q   <= 1'b0;
      fwd_a_q    <= 2'b00;
      fwd_b_q    <= 2'b00;
`endif
    end else begin
      exe_vld_q  <= exe_vld_d;
      exe_wb_q   <= exe_wb_d;
      exe_dest_q <= exe_dest_d;
      mem_vld_q  <= mem_vld_d;
      mem_wb_q   <= mem_wb_d;
      mem_dest_q <= mem_dest_d;
      cnt_q      <= cnt_d;
`ifdef HAZARD_FORWARD_EN
      exe_mr_q   <= exe_mr_d;
      fwd_a_q    <= fwd_a_d;
      fwd_b_q    <= fwd_b_d;
`endif
    end
  end

  assign stall_cnt = cnt_q;
`ifdef HAZARD_FORWARD_EN
  assign fwd_sel_a = fwd_a_q;
  assign fwd_sel_b = fwd_b_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst, id_valid, id_two_src, id_wb_en, id_mem_r, br_taken, mem_busy;
  logic [4:0]  id_src1, id_src2, id_dest;
  logic        pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_freeze;
  logic [15:0] stall_cnt;
`ifdef HAZARD_FORWARD_EN
  logic [1:0]  fwd_sel_a, fwd_sel_b;
`endif
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic rst, vld; logic [4:0] s1, s2; logic two; logic [4:0] dest;
    logic wb, mr, br, busy; logic [4:0] exp_ctl; logic [15:0] exp_cnt;
  } vec_t;
  vec_t tv[$];

  localparam logic [4:0] C0  = 5'b00000;  // {pc, ifid_fz, flush, bubble, pipe}
  localparam logic [4:0] STL = 5'b11010;
  localparam logic [4:0] BRF = 5'b00110;
  localparam logic [4:0] BSY = 5'b11001;

  hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r(id_mem_r),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_freeze(pc_freeze),
    .ifid_freeze(ifid_freeze), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .pipe_freeze(pipe_freeze),
`ifdef HAZARD_FORWARD_EN
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
`endif
    .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic vl, logic [4:0] a, logic [4:0] b, logic t,
                              logic [4:0] d, logic w, logic m, logic br, logic bz,
                              logic [4:0] ec, logic [15:0] en);
    vec_t v;
    v.rst = r; v.vld = vl; v.s1 = a; v.s2 = b; v.two = t; v.dest = d;
    v.wb = w; v.mr = m; v.br = br; v.busy = bz; v.exp_ctl = ec; v.exp_cnt = en;
    return v;
  endfunction

  // Common instructions: idle, ADD writing r3, SUB reading r3/r4 writing r5.
  function automatic vec_t idle(logic [15:0] en);
    return mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C0, en);
  endfunction
  function automatic vec_t add3(logic [15:0] en);
    return mk(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, C0, en);
  endfunction
  function automatic vec_t sub(logic r, logic br, logic bz, logic [4:0] ec, logic [15:0] en);
    return mk(r, 1'b1, 5'd3, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, br, bz, ec, en);
  endfunction

  task automatic apply(input vec_t v);
    rst = v.rst; id_valid = v.vld; id_src1 = v.s1; id_src2 = v.s2; id_two_src = v.two;
    id_dest = v.dest; id_wb_en = v.wb; id_mem_r = v.mr; br_taken = v.br; mem_busy = v.busy;
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1 apply(v);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ctl();
    return {pc_freeze, ifid_freeze, ifid_flush, idex_bubble, pipe_freeze};
  endfunction

  initial begin
    apply(idle(16'd0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
`ifndef HAZARD_FORWARD_EN
    for (int i = 0; i < 4; i++) tv.push_back(idle(16'd0));
    // ADD r3 -> SUB r3: two stall cycles
    tv.push_back(add3(16'd0));
    tv.push_back(sub(1'b0, 1'b0, 1'b0, STL, 16'd0));
    tv.push_back(sub(1'b0, 1'b0, 1'b0, STL, 16'd1));
    tv.push_back(sub(1'b0, 1'b0, 1'b0, C0, 16'd2));
    for (int i = 0; i < 2; i++) tv.push_back(idle(16'd2));
    // producer writes r0, consumer reads r0: never a hazard
    tv.push_back(mk(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C0, 16'd2));
    tv.push_back(mk(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C0, 16'd2));
    for (int i = 0; i < 2; i++) tv.push_back(idle(16'd2));
    // src2 = r3 ignored when two_src = 0
    tv.push_back(add3(16'd2));
    tv.push_back(mk(1'b0, 1'b1, 5'd1, 5'd3, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C0, 16'd2));
    for (int i = 0; i < 3; i++) tv.push_back(idle(16'd2));
    // src2 = r3 with two_src = 1 stalls twice
    tv.push_back(add3(16'd2));
    tv.push_back(mk(1'b0, 1'b1, 5'd1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, STL, 16'd2));
    tv.push_back(mk(1'b0, 1'b1, 5'd1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, STL, 16'd3));
    tv.push_back(mk(1'b0, 1'b1, 5'd1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C0, 16'd4));
    for (int i = 0; i < 3; i++) tv.push_back(idle(16'd4));
    // taken branch overrides a pending hazard
    tv.push_back(add3(16'd4));
    tv.push_back(sub(1'b0, 1'b1, 1'b0, BRF, 16'd4));
    for (int i = 0; i < 3; i++) tv.push_back(idle(16'd4));
    // mem_busy for 3 cycles (br_taken ignored), then the two stalls resume
    tv.push_back(add3(16'd4));
    tv.push_back(sub(1'b0, 1'b0, 1'b1, BSY, 16'd4));
    tv.push_back(sub(1'b0, 1'b1, 1'b1, BSY, 16'd4));
    tv.push_back(sub(1'b0, 1'b0, 1'b1, BSY, 16'd4));
    tv.push_back(sub(1'b0, 1'b0, 1'b0, STL, 16'd4));
    tv.push_back(sub(1'b0, 1'b0, 1'b0, STL, 16'd5));
    tv.push_back(sub(1'b0, 1'b0, 1'b0, C0, 16'd6));
    for (int i = 0; i < 3; i++) tv.push_back(idle(16'd6));
    // reset in the middle of a stall
    tv.push_back(add3(16'd6));
    tv.push_back(sub(1'b0, 1'b0, 1'b0, STL, 16'd6));
    tv.push_back(sub(1'b1, 1'b0, 1'b0, STL, 16'd7));
    tv.push_back(sub(1'b0, 1'b0, 1'b0, C0, 16'd0));
    tv.push_back(idle(16'd0));

    foreach (tv[i]) begin
      step(tv[i]);
      chk($sformatf("ctl[%0d]", i), {11'd0, ctl()}, {11'd0, tv[i].exp_ctl});
      chk($sformatf("cnt[%0d]", i), stall_cnt, tv[i].exp_cnt);
    end

    // reset asserted while mem_busy holds a pending hazard
    step(add3(16'd0));
    step(sub(1'b0, 1'b0, 1'b1, BSY, 16'd0));
    chk("busy_pre_rst", {11'd0, ctl()}, {11'd0, BSY});
    step(sub(1'b1, 1'b0, 1'b1, BSY, 16'd0));
    step(sub(1'b0, 1'b0, 1'b0, C0, 16'd0));
    chk("busy_rst_ctl", {11'd0, ctl()}, {11'd0, C0});
    chk("busy_rst_cnt", stall_cnt, 16'd0);
`else
    // LD r5 -> ADD r5: one load-use stall, then MEM/WB forwarding on A
    step(mk(1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C0, 16'd0));
    chk("ld_issue", {11'd0, ctl()}, {11'd0, C0});
    step(mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, STL, 16'd0));
    chk("ld_use_stall", {11'd0, ctl()}, {11'd0, STL});
    step(mk(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C0, 16'd1));
    chk("ld_use_release", {11'd0, ctl()}, {11'd0, C0});
    step(idle(16'd1));
    chk("fwd_a_mem", {14'd0, fwd_sel_a}, 16'd2);
    chk("fwd_cnt", stall_cnt, 16'd1);
    // ADDI r6 -> SUB src2 r6: no stall, EXE/MEM forwarding on B
    step(idle(16'd1));
    step(mk(1'b0, 1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, C0, 16'd1));
    step(mk(1'b0, 1'b1, 5'd1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, C0, 16'd1));
    chk("addi_no_stall", {11'd0, ctl()}, {11'd0, C0});
    step(idle(16'd1));
    chk("fwd_b_exe", {14'd0, fwd_sel_b}, 16'd1);
    chk("fwd_a_rf", {14'd0, fwd_sel_a}, 16'd0);
    chk("fwd_cnt2", stall_cnt, 16'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
